// File: rtl/avmm_csr_pkg.sv
// Shared definitions for the Avalon-MM CSR responder: register addresses,
// bus widths, FSM state encoding and the out-of-range read pattern.
package avmm_csr_pkg;

    localparam int CSR_ADDR_W = 8;
    localparam int CSR_DATA_W = 32;

    localparam logic [CSR_ADDR_W-1:0] CSR_CONTROL_ADDR = 8'h00;
    localparam logic [CSR_ADDR_W-1:0] CSR_STATUS_ADDR  = 8'h01;

    localparam logic [CSR_DATA_W-1:0] CSR_ERR_DATA = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE,
        STALL,
        ACCEPT,
        RD_PEND
    } csr_state_e;

    // True when the word address falls inside the implemented register bank.
    function automatic logic csr_addr_ok(input logic [CSR_ADDR_W-1:0] addr,
                                         input int num_regs);
        return {1'b0, addr} < 9'(num_regs);
    endfunction

endpackage

// File: rtl/avmm_csr_responder_if.sv
// Avalon-MM command/response signals between the sequencer (master) and
// the CSR responder (slave).
interface avmm_csr_responder_if;
    import avmm_csr_pkg::*;

    logic [CSR_ADDR_W-1:0] address;
    logic                  read;
    logic                  write;
    logic [CSR_DATA_W-1:0] writedata;
    logic [CSR_DATA_W-1:0] readdata;
    logic                  readdatavalid;
    logic                  waitrequest;

    modport master (
        output address, read, write, writedata,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, read, write, writedata,
        output readdata, readdatavalid, waitrequest
    );

endinterface

// File: rtl/avmm_csr_ready_timer.sv
// Delayed ready flag: arming loads READY_DELAY into a saturating down-counter,
// ready reads 1 once the counter sits at zero while armed.
module avmm_csr_ready_timer #(
    parameter int READY_DELAY = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic arm,
    input  logic clear,
    output logic ready
);

    localparam logic [15:0] DELAY_LOAD = 16'(READY_DELAY);

    logic        armed;
    logic [15:0] cnt;

    // Clear has priority; arming only happens on a CONTROL[0] 0->1 commit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            armed <= 1'b0;
            cnt   <= '0;
        end else if (clear) begin
            armed <= 1'b0;
            cnt   <= '0;
        end else if (arm) begin
            armed <= 1'b1;
            cnt   <= DELAY_LOAD;
        end else if (armed && cnt != 16'd0) begin
            cnt <= cnt - 16'd1;
        end
    end

    assign ready = armed && (cnt == 16'd0);

endmodule

// File: rtl/avmm_csr_responder.sv
// Avalon-MM CSR responder: CONTROL/STATUS/scratch register bank with
// configurable wait states and read latency, one transaction at a time.
// Optional error reporting is enabled by defining AVMM_CSR_RESPONDER_ERR_EN.
module avmm_csr_responder
    import avmm_csr_pkg::*;
#(
    parameter int NUM_REGS     = 8,
    parameter int WAIT_STATES  = 1,
    parameter int READ_LATENCY = 2,
    parameter int READY_DELAY  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    avmm_csr_responder_if.slave   avmm,
    input  logic [CSR_DATA_W-1:0] status_in,
    output logic [CSR_DATA_W-1:0] ctrl_out,
    output logic                  err
);

    localparam logic [3:0] STALL_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [3:0] LAT_LOAD   = 4'(READ_LATENCY - 1);

    csr_state_e            state, next_state;
    logic [3:0]            stall_cnt, lat_cnt;
    logic [CSR_DATA_W-1:0] regs [NUM_REGS];
    logic [CSR_DATA_W-1:0] rd_word, readdata_q;
    logic                  waitrequest_q;
    logic                  cmd, addr_ok, do_write, do_read;
    logic                  ready, ready_arm, ready_clear;
    logic                  unused_status_bit;

    assign cmd      = avmm.read | avmm.write;
    assign addr_ok  = csr_addr_ok(avmm.address, NUM_REGS);
    assign do_write = (state == ACCEPT) && avmm.write;
    assign do_read  = (state == ACCEPT) && avmm.read && !avmm.write;

    // STATUS[0] is sourced from the ready timer, not the external input.
    assign unused_status_bit = status_in[0];

    // Next-state decode; a command dropped during STALL abandons the access.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (cmd) next_state = (WAIT_STATES == 0) ? ACCEPT : STALL;
            end
            STALL: begin
                if (!cmd)                   next_state = IDLE;
                else if (stall_cnt == 4'd0) next_state = ACCEPT;
            end
            ACCEPT: begin
                next_state = do_read ? RD_PEND : IDLE;
            end
            RD_PEND: begin
                if (lat_cnt == 4'd0) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Wait-state and read-latency down-counters, saturating at zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            lat_cnt   <= '0;
        end else begin
            if (state == IDLE && cmd)                        stall_cnt <= STALL_LOAD;
            else if (state == STALL && stall_cnt != 4'd0)    stall_cnt <= stall_cnt - 4'd1;
            if (do_read)                                     lat_cnt <= LAT_LOAD;
            else if (state == RD_PEND && lat_cnt != 4'd0)    lat_cnt <= lat_cnt - 4'd1;
        end
    end

    // Registered waitrequest, low only for the accept cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) waitrequest_q <= 1'b1;
        else       waitrequest_q <= (next_state != ACCEPT);
    end

    // Register bank writes; STATUS and out-of-range addresses are not writable.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (do_write) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (i != int'(CSR_STATUS_ADDR) && avmm.address == 8'(i))
                    regs[i] <= avmm.writedata;
            end
        end
    end

    // Read mux, STATUS combines the sampled external bits with ready.
    always_comb begin
`ifdef AVMM_CSR_RESPONDER_ERR_EN
        rd_word = CSR_ERR_DATA;
`else
        rd_word = '0;
`endif
        for (int i = 0; i < NUM_REGS; i++) begin
            if (avmm.address == 8'(i)) rd_word = regs[i];
        end
        if (avmm.address == CSR_STATUS_ADDR) rd_word = {status_in[31:1], ready};
    end

    // Read data is captured in the accept cycle and held for the response.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)        readdata_q <= '0;
        else if (do_read) readdata_q <= rd_word;
    end

    assign ready_arm   = do_write && avmm.address == CSR_CONTROL_ADDR &&
                         avmm.writedata[0] && !regs[0][0];
    assign ready_clear = do_write && avmm.address == CSR_CONTROL_ADDR &&
                         !avmm.writedata[0];

    avmm_csr_ready_timer #(
        .READY_DELAY (READY_DELAY)
    ) u_ready_timer (
        .clock (clock),
        .reset (reset),
        .arm   (ready_arm),
        .clear (ready_clear),
        .ready (ready)
    );

`ifdef AVMM_CSR_RESPONDER_ERR_EN
    logic err_q, err_set, err_clear;

    assign err_set   = (state == ACCEPT) &&
                       ((avmm.read && avmm.write) || (cmd && !addr_ok));
    assign err_clear = do_write && avmm.address == 8'(NUM_REGS - 1);

    // Sticky error flag; a new error in the same cycle beats the clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)          err_q <= 1'b0;
        else if (err_set)   err_q <= 1'b1;
        else if (err_clear) err_q <= 1'b0;
    end

    assign err = err_q;
`else
    logic unused_addr_ok;
    assign unused_addr_ok = addr_ok;
    assign err = 1'b0;
`endif

    assign ctrl_out           = regs[0];
    assign avmm.readdata      = readdata_q;
    assign avmm.readdatavalid = (state == RD_PEND) && (lat_cnt == 4'd0);
    assign avmm.waitrequest   = waitrequest_q;

endmodule

// File: tb/tb_avmm_csr_responder.sv
// Self-checking bench for avmm_csr_responder: directed table, corner-case
// sequences and randomized traffic against a cycle-stamped register model.
module tb_avmm_csr_responder;
    import avmm_csr_pkg::*;

    localparam int NUM_REGS     = 8;
    localparam int WAIT_STATES  = 1;
    localparam int READ_LATENCY = 2;
    localparam int READY_DELAY  = 16;
`ifdef AVMM_CSR_RESPONDER_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] status_in;
    logic [31:0] ctrl_out;
    logic        err;

    avmm_csr_responder_if avmm();

    avmm_csr_responder #(
        .NUM_REGS     (NUM_REGS),
        .WAIT_STATES  (WAIT_STATES),
        .READ_LATENCY (READ_LATENCY),
        .READY_DELAY  (READY_DELAY)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .avmm      (avmm),
        .status_in (status_in),
        .ctrl_out  (ctrl_out),
        .err       (err)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    int checks   = 0;
    int failures = 0;

    // Reference model: register contents, ready time stamp, sticky error.
    logic [31:0] m_regs [256];
    bit          m_armed;
    int          m_ready_cycle;
    bit          m_err;

    task automatic m_reset();
        for (int i = 0; i < 256; i++) m_regs[i] = '0;
        m_armed = 1'b0;
        m_ready_cycle = 0;
        m_err = 1'b0;
    endtask

    function automatic logic [31:0] m_read(input logic [7:0] a, input logic [31:0] st, input int c);
        if (int'(a) >= NUM_REGS) return ERR_EN ? 32'hDEADBEEF : 32'h0;
        if (a == 8'h01) return {st[31:1], (m_armed && c >= m_ready_cycle)};
        return m_regs[a];
    endfunction

    // Applies a write committed at the end of accept cycle c.
    task automatic m_write(input logic [7:0] a, input logic [31:0] d, input int c);
        if (int'(a) < NUM_REGS && a != 8'h01) begin
            if (a == 8'h00) begin
                if (d[0] && !m_regs[0][0]) begin
                    m_armed = 1'b1;
                    m_ready_cycle = c + 1 + READY_DELAY;
                end else if (!d[0]) begin
                    m_armed = 1'b0;
                end
            end
            m_regs[a] = d;
        end
        if (ERR_EN) begin
            if (int'(a) >= NUM_REGS)        m_err = 1'b1;
            else if (int'(a) == NUM_REGS-1) m_err = 1'b0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One complete bus transaction started from IDLE; returns once the
    // responder is back in IDLE.
    task automatic xact(input bit rd, input bit wr, input logic [7:0] a,
                        input logic [31:0] d, input string tag, output logic [31:0] rdata);
        int k;
        int n;
        int acc_cyc;
        bit acc;
        bit saw_rdv;
        logic [31:0] exp;
        rdata = '0;
        exp = '0;
        avmm.address = a;
        avmm.read = rd;
        avmm.write = wr;
        avmm.writedata = d;
        acc = 1'b0;
        k = 0;
        while (!acc && k < 40) begin
            tick();
            k++;
            if (avmm.waitrequest === 1'b0) acc = 1'b1;
        end
        chk({tag, "_accept_cycle"}, 32'(k), 32'(WAIT_STATES + 1));
        acc_cyc = cyc;
        if (rd && !wr) exp = m_read(a, status_in, acc_cyc);
        tick();
        avmm.read = 1'b0;
        avmm.write = 1'b0;
        chk({tag, "_wreq_after"}, 32'(avmm.waitrequest), 32'd1);
        if (wr) begin
            m_write(a, d, acc_cyc);
            if (rd && ERR_EN) m_err = 1'b1;
            chk({tag, "_ctrl_out"}, ctrl_out, m_regs[0]);
            chk({tag, "_err"}, 32'(err), 32'(m_err));
            saw_rdv = 1'b0;
            for (int i = 0; i < READ_LATENCY + 2; i++) begin
                if (avmm.readdatavalid !== 1'b0) saw_rdv = 1'b1;
                if (i < READ_LATENCY + 1) tick();
            end
            chk({tag, "_no_rdv"}, 32'(saw_rdv), 32'd0);
        end else begin
            if (ERR_EN && int'(a) >= NUM_REGS) m_err = 1'b1;
            n = 1;
            while (avmm.readdatavalid !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            chk({tag, "_rd_latency"}, 32'(n), 32'(READ_LATENCY));
            chk({tag, "_readdata"}, avmm.readdata, exp);
            rdata = avmm.readdata;
            tick();
            chk({tag, "_rdv_pulse"}, 32'(avmm.readdatavalid), 32'd0);
            chk({tag, "_err"}, 32'(err), 32'(m_err));
        end
    endtask

    typedef struct {
        bit          rd;
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [12];

    initial begin
        logic [31:0] rdata;
        int          commit;
        int          k;
        bit          acc, saw0, saw1, saw;
        logic [7:0]  a;
        int          op;

        tbl[0]  = '{0, 1, 8'h02, 32'hA5A5_5A5A, 32'h0};
        tbl[1]  = '{1, 0, 8'h02, 32'h0,         32'hA5A5_5A5A};
        tbl[2]  = '{0, 1, 8'h03, 32'h1234_5678, 32'h0};
        tbl[3]  = '{0, 1, 8'h07, 32'hCAFE_F00D, 32'h0};
        tbl[4]  = '{1, 0, 8'h07, 32'h0,         32'hCAFE_F00D};
        tbl[5]  = '{1, 0, 8'h20, 32'h0,         ERR_EN ? 32'hDEAD_BEEF : 32'h0};
        tbl[6]  = '{0, 1, 8'h01, 32'hFFFF_FFFF, 32'h0};
        tbl[7]  = '{1, 0, 8'h01, 32'h0,         32'h8000_0002};
        tbl[8]  = '{0, 1, 8'h07, 32'h0,         32'h0};
        tbl[9]  = '{1, 0, 8'h03, 32'h0,         32'h1234_5678};
        tbl[10] = '{0, 1, 8'h40, 32'h1111_1111, 32'h0};
        tbl[11] = '{1, 0, 8'h04, 32'h0,         32'h0};

        reset = 1'b1;
        avmm.address = '0;
        avmm.read = 1'b0;
        avmm.write = 1'b0;
        avmm.writedata = '0;
        status_in = 32'h8000_0003;
        m_reset();
        repeat (3) tick();
        chk("rst_waitrequest", 32'(avmm.waitrequest), 32'd1);
        chk("rst_readdatavalid", 32'(avmm.readdatavalid), 32'd0);
        chk("rst_readdata", avmm.readdata, 32'h0);
        chk("rst_ctrl_out", ctrl_out, 32'h0);
        chk("rst_err", 32'(err), 32'd0);
        reset = 1'b0;
        tick();
        chk("post_rst_waitrequest", 32'(avmm.waitrequest), 32'd1);

        // Directed table
        for (int i = 0; i < 12; i++) begin
            xact(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].data, $sformatf("tbl%0d", i), rdata);
            if (tbl[i].rd) chk($sformatf("tbl%0d_expect", i), rdata, tbl[i].exp);
        end

        // CONTROL write timing, then ready polling
        tick();
        xact(0, 1, 8'h00, 32'h1, "ctl_set", rdata);
        chk("ctl_set_value", ctrl_out, 32'h1);
        xact(0, 1, 8'h00, 32'h0, "ctl_clr", rdata);
        xact(0, 1, 8'h00, 32'h1, "ctl_arm", rdata);
        commit = cyc - 1;
        saw0 = 1'b0;
        saw1 = 1'b0;
        k = 0;
        while (cyc < commit + 1 + READY_DELAY + 8 && k < 40) begin
            xact(1, 0, 8'h01, 32'h0, "poll", rdata);
            if (rdata[0]) saw1 = 1'b1;
            else          saw0 = 1'b1;
            if (k == 0) xact(0, 1, 8'h00, 32'h1, "ctl_rewrite", rdata);
            k++;
        end
        chk("poll_saw_not_ready", 32'(saw0), 32'd1);
        chk("poll_saw_ready", 32'(saw1), 32'd1);
        xact(0, 1, 8'h00, 32'h0, "ctl_off", rdata);
        xact(1, 0, 8'h01, 32'h0, "poll_off", rdata);
        chk("poll_off_bit0", 32'(rdata[0]), 32'd0);

        // Simultaneous read+write: write wins
        xact(0, 1, 8'(NUM_REGS - 1), 32'h0, "err_clr", rdata);
        xact(1, 1, 8'h03, 32'h5, "rdwr", rdata);
        chk("rdwr_err", 32'(err), ERR_EN ? 32'd1 : 32'd0);
        xact(1, 0, 8'h03, 32'h0, "rdwr_rb", rdata);
        chk("rdwr_reg3", rdata, 32'h5);

        // Command dropped before acceptance
        avmm.address = 8'h04;
        avmm.writedata = 32'h7777_7777;
        avmm.write = 1'b1;
        tick();
        avmm.write = 1'b0;
        saw = 1'b0;
        repeat (5) begin
            if (avmm.waitrequest !== 1'b1 || avmm.readdatavalid !== 1'b0) saw = 1'b1;
            tick();
        end
        chk("drop_no_accept", 32'(saw), 32'd0);
        xact(1, 0, 8'h04, 32'h0, "drop_rb", rdata);
        chk("drop_reg4", rdata, 32'h0);

        // Randomized traffic against the model
        for (int t = 0; t < 60; t++) begin
            repeat ($urandom_range(0, 6)) tick();
            status_in = $urandom;
            op = int'($urandom_range(0, 19));
            if (op < 4)       a = 8'($urandom_range(NUM_REGS, 255));
            else if (op < 8)  a = 8'h00;
            else if (op < 11) a = 8'h01;
            else              a = 8'($urandom_range(0, NUM_REGS - 1));
            op = int'($urandom_range(0, 19));
            if (op < 9)       xact(0, 1, a, $urandom, $sformatf("rnd%0d", t), rdata);
            else if (op < 18) xact(1, 0, a, 32'h0, $sformatf("rnd%0d", t), rdata);
            else              xact(1, 1, a, $urandom, $sformatf("rnd%0d", t), rdata);
        end

        // Reset during RD_PEND, one cycle before the response
        status_in = 32'h0;
        xact(0, 1, 8'h02, 32'h0BAD_F00D, "pre_rst_wr2", rdata);
        xact(0, 1, 8'h00, 32'h3, "pre_rst_ctl", rdata);
        avmm.address = 8'h02;
        avmm.read = 1'b1;
        acc = 1'b0;
        k = 0;
        while (!acc && k < 40) begin
            tick();
            k++;
            if (avmm.waitrequest === 1'b0) acc = 1'b1;
        end
        chk("rst_rd_accept", 32'(acc), 32'd1);
        tick();
        avmm.read = 1'b0;
        chk("rst_rd_pending", 32'(avmm.readdatavalid), 32'd0);
        reset = 1'b1;
        #1;
        chk("midrst_readdatavalid", 32'(avmm.readdatavalid), 32'd0);
        chk("midrst_waitrequest", 32'(avmm.waitrequest), 32'd1);
        chk("midrst_ctrl_out", ctrl_out, 32'h0);
        chk("midrst_readdata", avmm.readdata, 32'h0);
        chk("midrst_err", 32'(err), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        m_reset();
        saw = 1'b0;
        repeat (6) begin
            tick();
            if (avmm.readdatavalid !== 1'b0 || avmm.waitrequest !== 1'b1) saw = 1'b1;
        end
        chk("postrst_quiet", 32'(saw), 32'd0);
        xact(1, 0, 8'h02, 32'h0, "postrst_rb", rdata);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
